// File: rtl/palette_color_mapper.sv
// rtl/palette_color_mapper.sv - three-stage layer priority, palette lookup, background/blank/fade pipeline
module palette_color_mapper #(
    parameter int NUM_LAYERS = 2,
    parameter int IDX_W      = 4,
    parameter int PAL_SETS   = 4,
    parameter int COLOR_W    = 4,
    localparam int PSEL_W    = (PAL_SETS > 1) ? $clog2(PAL_SETS) : 1,
    localparam int AW        = PSEL_W + IDX_W,
    localparam int CW3       = 3 * COLOR_W
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         pix_valid,
    input  logic [NUM_LAYERS-1:0]        layer_en,
    input  logic [NUM_LAYERS*IDX_W-1:0]  layer_idx,
    input  logic [NUM_LAYERS*PSEL_W-1:0] layer_pal,
    input  logic                         pal_we,
    input  logic [AW-1:0]                pal_waddr,
    input  logic [CW3-1:0]               pal_wdata,
    input  logic [CW3-1:0]               bg_color,
    input  logic [1:0]                   fade,
    output logic [COLOR_W-1:0]           Red,
    output logic [COLOR_W-1:0]           Green,
    output logic [COLOR_W-1:0]           Blue,
    output logic                         out_valid
);

    localparam int DEPTH = PAL_SETS * (2 ** IDX_W);

    // Non-power-of-two set counts leave addresses past the RAM end; fold them
    // back once, which is enough because the address range is below 2*DEPTH.
    function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] a);
        if (32'(a) >= DEPTH) begin
            return a - AW'(DEPTH);
        end
        return a;
    endfunction

    logic [CW3-1:0]     mem [DEPTH];

    logic [AW-1:0]      raddr_d, raddr_q;
    logic               hit_d, hit_q;
    logic               v1_q;

    logic [CW3-1:0]     rgb_q;
    logic               hit2_q;
    logic               v2_q;
    logic [1:0]         fade2_q;

    logic [CW3-1:0]     color;
    logic [COLOR_W-1:0] red_d, green_d, blue_d;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               out_valid_q;

    // S1 priority: scan from the lowest priority upward so the lowest opaque layer wins
    always_comb begin
        raddr_d = '0;
        hit_d   = 1'b0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (layer_en[k] && (layer_idx[k*IDX_W +: IDX_W] != '0)) begin
                raddr_d = {layer_pal[k*PSEL_W +: PSEL_W], layer_idx[k*IDX_W +: IDX_W]};
                hit_d   = 1'b1;
            end
        end
    end

    // S1 registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            raddr_q <= '0;
            hit_q   <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            raddr_q <= raddr_d;
            hit_q   <= hit_d;
            v1_q    <= pix_valid;
        end
    end

    // Palette write port; contents survive reset so software setup is kept
    always_ff @(posedge Clk) begin
        if (pal_we) begin
            mem[wrap_addr(pal_waddr)] <= pal_wdata;
        end
    end

    // S2 lookup: non-blocking read sees the pre-write word on a same-edge collision
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q   <= '0;
            hit2_q  <= 1'b0;
            v2_q    <= 1'b0;
            fade2_q <= 2'd0;
        end else begin
            rgb_q   <= mem[wrap_addr(raddr_q)];
            hit2_q  <= hit_q;
            v2_q    <= v1_q;
            fade2_q <= fade;
        end
    end

    // S3 colour select, blanking and per-channel fade shift
    always_comb begin
        color   = hit2_q ? rgb_q : bg_color;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (v2_q) begin
            red_d   = color[3*COLOR_W-1 -: COLOR_W] >> fade2_q;
            green_d = color[2*COLOR_W-1 -: COLOR_W] >> fade2_q;
            blue_d  = color[COLOR_W-1   -: COLOR_W] >> fade2_q;
        end
    end

    // S3 output register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            out_valid_q <= v2_q;
        end
    end

    assign Red       = red_q;
    assign Green     = green_q;
    assign Blue      = blue_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_palette_color_mapper.sv
// tb/tb_palette_color_mapper.sv - directed vector bench for palette_color_mapper
module tb_palette_color_mapper;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid;
    logic [1:0]  layer_en;
    logic [7:0]  layer_idx;
    logic [3:0]  layer_pal;
    logic        pal_we;
    logic [5:0]  pal_waddr;
    logic [11:0] pal_wdata;
    logic [11:0] bg_color;
    logic [1:0]  fade;
    logic [3:0]  Red, Green, Blue;
    logic        out_valid;

    int n_vec = 0;
    int n_bad = 0;

    palette_color_mapper dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid),
        .layer_en(layer_en), .layer_idx(layer_idx), .layer_pal(layer_pal),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .bg_color(bg_color), .fade(fade),
        .Red(Red), .Green(Green), .Blue(Blue), .out_valid(out_valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  en;
        logic [3:0]  i0, i1;
        logic [1:0]  p0, p1;
        logic        pv;
        logic [1:0]  fd;
        logic [11:0] bg;
        logic        ev;
        logic [11:0] ergb;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got v=%0b rgb=%03h, expected v=%0b rgb=%03h",
                     name, got[12], got[11:0], exp[12], exp[11:0]);
        end
    endtask

    function automatic logic [12:0] dut_out();
        return {out_valid, Red, Green, Blue};
    endfunction

    task automatic drive_px(input logic pv, input logic [1:0] en,
                            input logic [3:0] i0, input logic [1:0] p0,
                            input logic [3:0] i1, input logic [1:0] p1);
        pix_valid = pv;
        layer_en  = en;
        layer_idx = {i1, i0};
        layer_pal = {p1, p0};
    endtask

    task automatic pal_write(input logic [5:0] a, input logic [11:0] d);
        @(negedge Clk);
        pal_we    = 1'b1;
        pal_waddr = a;
        pal_wdata = d;
        @(negedge Clk);
        pal_we    = 1'b0;
    endtask

    function automatic logic [11:0] strm_val(input int k);
        logic [3:0] r, g, b;
        r = 4'(k);
        g = 4'(15 - k);
        b = 4'(k + 3);
        return {r, g, b};
    endfunction

    initial begin
        Reset_n = 1'b0;
        pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
        bg_color = '0; fade = 2'd0;
        drive_px(1'b0, 2'b00, 4'd0, 2'd0, 4'd0, 2'd0);

        // reset state
        #12;
        check("reset_state", dut_out(), 13'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        pal_write({2'd1, 4'd5}, 12'hF80);
        pal_write({2'd0, 4'd3}, 12'h0F0);
        pal_write({2'd0, 4'd2}, 12'h00F);
        pal_write({2'd3, 4'd7}, 12'h555);
        for (int k = 1; k <= 8; k++) pal_write({2'd2, 4'(k)}, strm_val(k));

        //        en     i0 i1  p0 p1 pv fd bg       ev ergb
        vecs[0]  = '{2'b01, 5, 0, 1, 0, 1, 0, 12'h000, 1, 12'hF80};
        vecs[1]  = '{2'b11, 0, 3, 0, 0, 1, 0, 12'h000, 1, 12'h0F0};
        vecs[2]  = '{2'b11, 2, 3, 0, 0, 1, 0, 12'h000, 1, 12'h00F};
        vecs[3]  = '{2'b11, 0, 0, 0, 0, 1, 0, 12'h123, 1, 12'h123};
        vecs[4]  = '{2'b11, 0, 0, 0, 0, 1, 1, 12'h123, 1, 12'h011};
        vecs[5]  = '{2'b11, 0, 0, 0, 0, 0, 1, 12'h123, 0, 12'h000};
        vecs[6]  = '{2'b00, 5, 3, 1, 0, 1, 0, 12'h123, 1, 12'h123};
        vecs[7]  = '{2'b01, 5, 0, 1, 0, 1, 3, 12'h000, 1, 12'h110};
        vecs[8]  = '{2'b10, 5, 3, 1, 0, 1, 0, 12'h000, 1, 12'h0F0};
        vecs[9]  = '{2'b11, 0, 0, 0, 0, 1, 2, 12'hFFF, 1, 12'h333};
        vecs[10] = '{2'b11, 2, 5, 0, 1, 0, 0, 12'h000, 0, 12'h000};

        // each vector held alone for three edges, then output compared
        for (int i = 0; i < 11; i++) begin
            @(negedge Clk);
            drive_px(vecs[i].pv, vecs[i].en, vecs[i].i0, vecs[i].p0, vecs[i].i1, vecs[i].p1);
            fade     = vecs[i].fd;
            bg_color = vecs[i].bg;
            repeat (3) @(negedge Clk);
            check($sformatf("vec%0d", i), dut_out(), {vecs[i].ev, vecs[i].ergb});
        end

        // latency exactly three: value must not appear after only two edges
        @(negedge Clk);
        fade = 2'd0; bg_color = 12'h000;
        drive_px(1'b0, 2'b00, 4'd0, 2'd0, 4'd0, 2'd0);
        repeat (3) @(negedge Clk);
        drive_px(1'b1, 2'b01, 4'd5, 2'd1, 4'd0, 2'd0);
        @(negedge Clk);
        drive_px(1'b0, 2'b00, 4'd0, 2'd0, 4'd0, 2'd0);
        @(negedge Clk);
        check("lat_edge2", dut_out(), 13'h0);
        @(negedge Clk);
        check("lat_edge3", dut_out(), {1'b1, 12'hF80});

        // back-to-back stream of eight pixels
        for (int t = 0; t < 11; t++) begin
            @(negedge Clk);
            if (t >= 3) check($sformatf("stream%0d", t - 3), dut_out(), {1'b1, strm_val(t - 2)});
            if (t < 8) drive_px(1'b1, 2'b01, 4'(t + 1), 2'd2, 4'd0, 2'd0);
            else       drive_px(1'b0, 2'b00, 4'd0, 2'd0, 4'd0, 2'd0);
        end

        // read-first collision: write lands on the edge that S2 reads pixel A
        @(negedge Clk);
        drive_px(1'b1, 2'b01, 4'd7, 2'd3, 4'd0, 2'd0);
        @(negedge Clk);
        pal_we = 1'b1; pal_waddr = {2'd3, 4'd7}; pal_wdata = 12'hAAA;
        @(negedge Clk);
        pal_we = 1'b0;
        drive_px(1'b0, 2'b00, 4'd0, 2'd0, 4'd0, 2'd0);
        @(negedge Clk);
        check("rfirst_old", dut_out(), {1'b1, 12'h555});
        @(negedge Clk);
        check("rfirst_new", dut_out(), {1'b1, 12'hAAA});

        // reset with pixels in flight
        for (int t = 0; t < 5; t++) begin
            @(negedge Clk);
            drive_px(1'b1, 2'b01, 4'd5, 2'd1, 4'd0, 2'd0);
        end
        check("pre_reset", dut_out(), {1'b1, 12'hF80});
        #2;
        Reset_n = 1'b0;
        #1;
        check("reset_async", dut_out(), 13'h0);
        @(negedge Clk);
        drive_px(1'b0, 2'b00, 4'd0, 2'd0, 4'd0, 2'd0);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("flight_flushed", dut_out(), 13'h0);
        drive_px(1'b1, 2'b01, 4'd5, 2'd1, 4'd0, 2'd0);
        @(negedge Clk);
        drive_px(1'b0, 2'b00, 4'd0, 2'd0, 4'd0, 2'd0);
        @(negedge Clk);
        check("post_rst_edge2", dut_out(), 13'h0);
        @(negedge Clk);
        check("post_rst_first", dut_out(), {1'b1, 12'hF80});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
